// File: rtl/bsg_manycore_vcache_dma_mux.sv
// bsg_manycore_vcache_dma_mux: shares one memory DMA channel among num_caches_p vcaches.
// Ports: dma_pkt_*/dma_data_* are per-cache slices (cache i = slice i); mem_* faces memory.

module bsg_manycore_vcache_dma_mux_tag_fifo #(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push,
  input  logic [width_p-1:0] din,
  input  logic               pop,
  output logic [width_p-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0]   rptr_r, wptr_r;
  logic [cnt_w-1:0]   cnt_r;
  logic               do_push, do_pop;

  function automatic logic [ptr_w-1:0] nxt(
    input logic [ptr_w-1:0] p
  );
    return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_r == cnt_w'(els_p));
  assign empty   = (cnt_r == '0);
  assign head    = mem_r[rptr_r];
  // fullness is the registered count: a full fifo never
  // takes a push, even when it pops in the same cycle
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_r[wptr_r] <= din;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (do_push) wptr_r <= nxt(wptr_r);
      if (do_pop)  rptr_r <= nxt(rptr_r);
      unique case ({do_push, do_pop})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

module bsg_manycore_vcache_dma_mux #(
  parameter int num_caches_p          = 2,
  parameter int addr_width_p          = 28,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int dma_data_width_p      = 32,
  parameter int max_outstanding_p     = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,

  input  logic [num_caches_p*(1+addr_width_p)-1:0] dma_pkt_i,
  input  logic [num_caches_p-1:0]                  dma_pkt_v_i,
  output logic [num_caches_p-1:0]                  dma_pkt_yumi_o,

  output logic [num_caches_p*dma_data_width_p-1:0] dma_data_o,
  output logic [num_caches_p-1:0]                  dma_data_v_o,
  input  logic [num_caches_p-1:0]                  dma_data_ready_i,

  input  logic [num_caches_p*dma_data_width_p-1:0] dma_data_i,
  input  logic [num_caches_p-1:0]                  dma_data_v_i,
  output logic [num_caches_p-1:0]                  dma_data_yumi_o,

  output logic [addr_width_p:0]                    mem_pkt_o,
  output logic                                     mem_pkt_v_o,
  input  logic                                     mem_pkt_yumi_i,

  input  logic [dma_data_width_p-1:0]              mem_data_i,
  input  logic                                     mem_data_v_i,
  output logic                                     mem_data_ready_o,

  output logic [dma_data_width_p-1:0]              mem_data_o,
  output logic                                     mem_data_v_o,
  input  logic                                     mem_data_yumi_i
);

  localparam int beats_lp =
    block_size_in_words_p * data_width_p / dma_data_width_p;
  localparam int pkt_width_lp = 1 + addr_width_p;
  localparam int lg_caches_lp =
    (num_caches_p > 1) ? $clog2(num_caches_p) : 1;
  localparam int lg_beats_lp  = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  logic [pkt_width_lp-1:0]     pkt_a  [num_caches_p];
  logic [dma_data_width_p-1:0] wdat_a [num_caches_p];
  logic [num_caches_p-1:0]     wnr, elig;

  logic [lg_caches_lp-1:0] rr_r, win;
  logic                    any, grant;

  logic [lg_caches_lp-1:0] rd_head, wr_head;
  logic rd_full, rd_empty, wr_full, wr_empty;
  logic rd_xfer, rd_last, wr_xfer, wr_last;
  logic [lg_beats_lp-1:0]  rd_cnt_r, wr_cnt_r;

  always_comb begin
    for (int i = 0; i < num_caches_p; i++) begin
      pkt_a[i]  = dma_pkt_i[i*pkt_width_lp +: pkt_width_lp];
      wdat_a[i] = dma_data_i[i*dma_data_width_p +: dma_data_width_p];
      wnr[i]    = pkt_a[i][pkt_width_lp-1];
      // gated by reset so requests stay quiet while held in reset
      elig[i]   = reset_n_i & dma_pkt_v_i[i]
                & (wnr[i] ? ~wr_full : ~rd_full);
    end
  end

  // walk down so the lowest offset from rr_r wins
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = num_caches_p - 1; k >= 0; k--) begin
      if (elig[(int'(rr_r) + k) % num_caches_p]) begin
        win = lg_caches_lp'((int'(rr_r) + k) % num_caches_p);
        any = 1'b1;
      end
    end
  end

  assign grant          = any & mem_pkt_yumi_i;
  assign mem_pkt_v_o    = any;
  assign mem_pkt_o      = any ? pkt_a[win] : '0;
  assign dma_pkt_yumi_o = grant ? (num_caches_p'(1) << win) : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_r <= '0;
    end else if (grant) begin
      rr_r <= (win == lg_caches_lp'(num_caches_p - 1)) ? '0 : win + 1'b1;
    end
  end

  bsg_manycore_vcache_dma_mux_tag_fifo #(
    .width_p(lg_caches_lp),
    .els_p  (max_outstanding_p)
  ) rd_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push     (grant & ~wnr[win]),
    .din      (win),
    .pop      (rd_xfer & rd_last),
    .head     (rd_head),
    .full     (rd_full),
    .empty    (rd_empty)
  );

  bsg_manycore_vcache_dma_mux_tag_fifo #(
    .width_p(lg_caches_lp),
    .els_p  (max_outstanding_p)
  ) wr_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push     (grant & wnr[win]),
    .din      (win),
    .pop      (wr_xfer & wr_last),
    .head     (wr_head),
    .full     (wr_full),
    .empty    (wr_empty)
  );

  // read fill: steer memory beats to the oldest read owner
  assign dma_data_o       = {num_caches_p{mem_data_i}};
  assign mem_data_ready_o = ~rd_empty & dma_data_ready_i[rd_head];
  assign dma_data_v_o     = rd_empty ? '0
                          : (num_caches_p'(mem_data_v_i) << rd_head);
  assign rd_xfer = mem_data_ready_o & mem_data_v_i;
  assign rd_last = (rd_cnt_r == lg_beats_lp'(beats_lp - 1));

  // write-back: pull beats from the oldest write owner
  assign mem_data_v_o    = ~wr_empty & dma_data_v_i[wr_head];
  assign mem_data_o      = wr_empty ? '0 : wdat_a[wr_head];
  assign dma_data_yumi_o = wr_empty ? '0
                         : (num_caches_p'(mem_data_yumi_i) << wr_head);
  assign wr_xfer = ~wr_empty & mem_data_yumi_i;
  assign wr_last = (wr_cnt_r == lg_beats_lp'(beats_lp - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_cnt_r <= '0;
      wr_cnt_r <= '0;
    end else begin
      if (rd_xfer) rd_cnt_r <= rd_last ? '0 : rd_cnt_r + 1'b1;
      if (wr_xfer) wr_cnt_r <= wr_last ? '0 : wr_cnt_r + 1'b1;
    end
  end

  // memory must never return data nobody asked for
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(mem_data_v_i && rd_empty));

endmodule

// File: tb/tb_bsg_manycore_vcache_dma_mux.sv
// tb_bsg_manycore_vcache_dma_mux: vectors, directed corners and random run
// against a queue-based model of the shared DMA channel.

module tb_bsg_manycore_vcache_dma_mux;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int B  = 8;
  localparam int PW = AW + 1;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b1;
  logic [N*PW-1:0] dma_pkt_i;
  logic [N-1:0]    dma_pkt_v_i, dma_pkt_yumi_o;
  logic [N*DW-1:0] dma_data_o;
  logic [N-1:0]    dma_data_v_o, dma_data_ready_i;
  logic [N*DW-1:0] dma_data_i;
  logic [N-1:0]    dma_data_v_i, dma_data_yumi_o;
  logic [PW-1:0]   mem_pkt_o;
  logic            mem_pkt_v_o, mem_pkt_yumi_i;
  logic [DW-1:0]   mem_data_i;
  logic            mem_data_v_i, mem_data_ready_o;
  logic [DW-1:0]   mem_data_o;
  logic            mem_data_v_o, mem_data_yumi_i;

  always #5 clk_i = ~clk_i;

  bsg_manycore_vcache_dma_mux #(
    .num_caches_p(N), .addr_width_p(AW), .data_width_p(32),
    .block_size_in_words_p(8), .dma_data_width_p(DW),
    .max_outstanding_p(D)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i),
    .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
    .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i),
    .dma_data_yumi_o(dma_data_yumi_o),
    .mem_pkt_o(mem_pkt_o), .mem_pkt_v_o(mem_pkt_v_o),
    .mem_pkt_yumi_i(mem_pkt_yumi_i),
    .mem_data_i(mem_data_i), .mem_data_v_i(mem_data_v_i),
    .mem_data_ready_o(mem_data_ready_o),
    .mem_data_o(mem_data_o), .mem_data_v_o(mem_data_v_o),
    .mem_data_yumi_i(mem_data_yumi_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0]  p_v, p_wnr, p_rdy, p_dv;
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wd [N];
  logic [DW-1:0] m_d;
  bit r_pkt_yumi, r_mem_v, r_mem_yumi;

  int rd_q[$];
  int wr_q[$];
  int rr, rd_beat, wr_beat;

  bit e_v, e_rdy, e_mv;
  int e_win;
  logic [PW-1:0] e_pkt;
  logic [N-1:0]  e_pyumi, e_dvo, e_dyumi;
  logic [DW-1:0] e_md;

  logic [N-1:0]  s_pyumi, s_dvo, s_dyumi;
  logic          s_pv, s_rdy, s_mv;
  logic [DW-1:0] s_md;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_model();
    for (int i = 0; i < N; i++) begin
      dma_pkt_i[i*PW +: PW] = {p_wnr[i], p_addr[i]};
      dma_data_i[i*DW +: DW] = p_wd[i];
    end
    dma_pkt_v_i = p_v;
    dma_data_ready_i = p_rdy;
    dma_data_v_i = p_dv;
    mem_data_i = m_d;
    e_v = 0;
    e_win = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (rr + k) % N;
      if (!e_v && p_v[c] &&
          (p_wnr[c] ? wr_q.size() < D : rd_q.size() < D)) begin
        e_v = 1;
        e_win = c;
      end
    end
    mem_pkt_yumi_i = e_v && r_pkt_yumi;
    e_pkt = e_v ? {p_wnr[e_win], p_addr[e_win]} : '0;
    e_pyumi = mem_pkt_yumi_i ? (N'(1) << e_win) : '0;
    e_dvo = '0;
    e_rdy = 0;
    mem_data_v_i = 0;
    if (rd_q.size() > 0) begin
      mem_data_v_i = r_mem_v;
      e_dvo = r_mem_v ? (N'(1) << rd_q[0]) : '0;
      e_rdy = p_rdy[rd_q[0]];
    end
    e_mv = 0;
    e_md = '0;
    e_dyumi = '0;
    mem_data_yumi_i = 0;
    if (wr_q.size() > 0) begin
      e_mv = p_dv[wr_q[0]];
      e_md = p_wd[wr_q[0]];
      mem_data_yumi_i = r_mem_yumi && e_mv;
      e_dyumi = mem_data_yumi_i ? (N'(1) << wr_q[0]) : '0;
    end
  endtask

  task automatic check_update();
    s_pv = mem_pkt_v_o;
    s_pyumi = dma_pkt_yumi_o;
    s_dvo = dma_data_v_o;
    s_rdy = mem_data_ready_o;
    s_mv = mem_data_v_o;
    s_md = mem_data_o;
    s_dyumi = dma_data_yumi_o;
    chk("mem_pkt_v", mem_pkt_v_o, e_v);
    if (e_v) chk("mem_pkt", mem_pkt_o, e_pkt);
    chk("pkt_yumi", dma_pkt_yumi_o, e_pyumi);
    chk("fill_v", dma_data_v_o, e_dvo);
    chk("mem_ready", mem_data_ready_o, e_rdy);
    chk("fill_data", dma_data_o, {N{m_d}});
    chk("wr_v", mem_data_v_o, e_mv);
    if (e_mv) chk("wr_data", mem_data_o, e_md);
    chk("wb_yumi", dma_data_yumi_o, e_dyumi);
    if (rd_q.size() > 0 && mem_data_v_i && p_rdy[rd_q[0]]) begin
      rd_beat++;
      if (rd_beat == B) begin
        rd_beat = 0;
        void'(rd_q.pop_front());
      end
    end
    if (mem_data_yumi_i) begin
      wr_beat++;
      if (wr_beat == B) begin
        wr_beat = 0;
        void'(wr_q.pop_front());
      end
    end
    if (mem_pkt_yumi_i) begin
      if (p_wnr[e_win]) wr_q.push_back(e_win);
      else rd_q.push_back(e_win);
      rr = (e_win + 1) % N;
    end
  endtask

  task automatic cycle();
    drive_model();
    @(negedge clk_i);
    check_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 0;
    dma_pkt_v_i = '1;
    mem_pkt_yumi_i = 1;
    dma_data_ready_i = '1;
    mem_data_v_i = 1;
    dma_data_v_i = '1;
    mem_data_yumi_i = 1;
    #1;
    chk("rst_pkt_v", mem_pkt_v_o, 0);
    chk("rst_pkt_yumi", dma_pkt_yumi_o, 0);
    chk("rst_ready", mem_data_ready_o, 0);
    chk("rst_fill_v", dma_data_v_o, 0);
    chk("rst_wr_v", mem_data_v_o, 0);
    chk("rst_wb_yumi", dma_data_yumi_o, 0);
    rd_q.delete();
    wr_q.delete();
    rr = 0;
    rd_beat = 0;
    wr_beat = 0;
    p_v = '0;
    p_dv = '0;
    r_pkt_yumi = 0;
    r_mem_v = 0;
    r_mem_yumi = 0;
    mem_data_v_i = 0;
    mem_pkt_yumi_i = 0;
    mem_data_yumi_i = 0;
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1;
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] wnr;
    bit           yumi;
    bit           ev;
    int           win;
    logic [N-1:0] pyumi;
  } vec_t;

  vec_t tv[9];
  int   ord[8];
  int   nw, st;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    tv[0] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 0, 4'b0000};
    tv[1] = '{4'b1010, 4'b0000, 1'b0, 1'b1, 1, 4'b0000};
    tv[2] = '{4'b1010, 4'b0000, 1'b1, 1'b1, 1, 4'b0010};
    tv[3] = '{4'b1010, 4'b0000, 1'b1, 1'b1, 3, 4'b1000};
    tv[4] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 0, 4'b0001};
    tv[5] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 0, 4'b0001};
    tv[6] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 0, 4'b0000};
    tv[7] = '{4'b1111, 4'b0100, 1'b1, 1'b1, 2, 4'b0100};
    tv[8] = '{4'b1111, 4'b0100, 1'b0, 1'b1, 2, 4'b0000};
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    p_v = '0; p_wnr = '0; p_rdy = '1; p_dv = '0; m_d = '0;
    for (int i = 0; i < N; i++) begin
      p_addr[i] = AW'(32'h100 * (i + 1));
      p_wd[i] = '0;
    end
    #2;
    do_reset();

    // arbitration and backpressure vectors from reset
    for (int i = 0; i < 9; i++) begin
      p_v = tv[i].v;
      p_wnr = tv[i].wnr;
      r_pkt_yumi = tv[i].yumi;
      drive_model();
      @(negedge clk_i);
      chk("tv_pkt_v", mem_pkt_v_o, tv[i].ev);
      if (tv[i].ev)
        chk("tv_pkt", mem_pkt_o, {tv[i].wnr[tv[i].win], p_addr[tv[i].win]});
      chk("tv_yumi", dma_pkt_yumi_o, tv[i].pyumi);
      check_update();
      @(posedge clk_i);
      #1;
    end
    do_reset();

    // fairness: all four busy, reads and writes split across both fifos
    p_v = '1; p_wnr = 4'b1010; r_pkt_yumi = 1;
    for (int g = 0; g < 8; g++) begin
      cycle();
      chk("fair_grant", s_pyumi, N'(1) << ord[g]);
    end
    cycle();
    chk("fair_all_full", s_pv, 0);
    do_reset();

    // single read from cache 1
    p_v = 4'b0010; p_wnr = '0; p_addr[1] = AW'(32'h100); r_pkt_yumi = 1;
    cycle();
    chk("rd1_grant", s_pyumi, 4'b0010);
    p_v = '0; r_mem_v = 1; p_rdy = '1;
    for (int k = 0; k < B; k++) begin
      m_d = DW'(k);
      cycle();
      chk("rd1_fill_v", s_dvo, 4'b0010);
    end
    r_mem_v = 0;
    cycle();
    chk("rd1_empty", s_rdy, 0);

    // cache 2 stalls for two cycles at beat 4
    p_v = 4'b0100;
    cycle();
    p_v = '0; r_mem_v = 1;
    for (int k = 0; k < 4; k++) begin
      m_d = DW'(k + 32'h40);
      cycle();
    end
    p_rdy[2] = 0;
    repeat (2) begin
      cycle();
      chk("stall_ready", s_rdy, 0);
      chk("stall_v", s_dvo, 4'b0100);
    end
    p_rdy[2] = 1;
    for (int k = 4; k < B; k++) begin
      m_d = DW'(k + 32'h40);
      cycle();
      chk("resume_ready", s_rdy, 1);
    end
    r_mem_v = 0;
    cycle();
    chk("stall_empty", s_rdy, 0);

    // cache 0 write-back while cache 1 fill is running
    p_v = 4'b0010; p_wnr = '0;
    cycle();
    p_v = 4'b0001; p_wnr = 4'b0001; r_mem_v = 1;
    cycle();
    p_v = '0;
    nw = 0; st = 0;
    for (int c = 0; c < 16; c++) begin
      p_dv = 4'b0011;
      p_wd[0] = DW'(32'hA0 + nw);
      p_wd[1] = DW'(32'hBAD);
      m_d = DW'($urandom);
      if (nw == 3 && st < 3) begin
        r_mem_yumi = 0;
        st++;
      end else begin
        r_mem_yumi = 1;
      end
      cycle();
      if (s_dyumi != '0) begin
        chk("ilv_src", s_dyumi, 4'b0001);
        chk("ilv_data", s_md, 32'hA0 + nw);
        nw++;
      end
    end
    chk("ilv_count", nw, 8);
    chk("ilv_wr_done", s_mv, 0);
    chk("ilv_rd_done", s_rdy, 0);
    p_dv = '0; r_mem_yumi = 0; r_mem_v = 0;

    // reset in the middle of a fill, then a clean read
    p_v = 4'b1000; p_wnr = '0;
    cycle();
    p_v = '0; r_mem_v = 1;
    for (int k = 0; k < 4; k++) begin
      m_d = DW'(k);
      cycle();
    end
    do_reset();
    p_v = 4'b1000; r_pkt_yumi = 1;
    cycle();
    p_v = '0; r_mem_v = 1;
    for (int k = 0; k < B; k++) begin
      m_d = DW'(k + 32'h70);
      cycle();
      chk("post_rst_beat", s_dvo, 4'b1000);
    end
    r_mem_v = 0;
    cycle();
    chk("post_rst_empty", s_rdy, 0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      p_v = N'($urandom);
      p_wnr = N'($urandom);
      for (int i = 0; i < N; i++) begin
        p_addr[i] = AW'($urandom);
        p_wd[i] = DW'($urandom);
        p_rdy[i] = ($urandom_range(0, 3) != 0);
        p_dv[i] = ($urandom_range(0, 3) != 0);
      end
      m_d = DW'($urandom);
      r_pkt_yumi = ($urandom_range(0, 2) != 0);
      r_mem_v = ($urandom_range(0, 3) != 0);
      r_mem_yumi = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
